// File: rtl/fetch_pc_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_pc_ctrl
//   Fetch-stage sequencer for the P6 pipeline. It owns the program counter and
//   the F/D handoff register, and it issues instruction-memory requests. The
//   memory may take several cycles to grant a request. Hazard-unit stalls are
//   absorbed without losing a granted instruction. MIPS delay-slot semantics
//   are kept: the word fetched after a branch is always delivered.
//
//   Optional feature macro: FETCH_ADEL_CHECK_EN
//     When defined, fetch addresses that are misaligned or outside
//     [PC_LO, PC_HI] are not sent to memory. Instead a zero instruction is
//     delivered with exc_adel_D=1. When the macro is undefined, exc_adel_D is
//     constant 0.
//
// Ports
//   clk           in   clock, rising edge
//   reset         in   asynchronous active-high reset
//   stall         in   hazard-unit freeze of F and D
//   redir_valid   in   D-stage branch taken / jal / jr this cycle
//   redir_target  in   redirect destination
//   imem_req      out  fetch request
//   imem_addr     out  fetch address (always pc_F)
//   imem_gnt      in   request accepted; imem_rdata valid in the same cycle
//   imem_rdata    in   instruction word
//   pc_F          out  current PC
//   instr_D       out  F/D instruction
//   pc_D          out  F/D PC
//   pc8_D         out  pc_D + 8 (link address)
//   valid_D       out  F/D holds a real instruction
//   exc_adel_D    out  fetch address error
// ---------------------------------------------------------------------------
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] PC_LO    = 32'h0000_3000,
  parameter logic [31:0] PC_HI    = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redir_valid,
  input  logic [31:0] redir_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_F,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc8_D,
  output logic        valid_D,
  output logic        exc_adel_D
);

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t      r_state, w_state_next;
  logic [31:0] r_pc, w_pc_next;
  logic        r_pend, w_pend_next;
  logic [31:0] r_pend_tgt, w_pend_tgt_next;
  logic [31:0] r_ibuf, w_ibuf_next;
  logic        r_ibuf_exc, w_ibuf_exc_next;
  logic [31:0] r_instr_d, w_instr_d_next;
  logic [31:0] r_pc_d, w_pc_d_next;
  logic        r_valid_d, w_valid_d_next;
  logic        r_exc_d, w_exc_d_next;

  logic        w_live_redir;
  logic        w_bad_pc;
  logic        w_gnt;
  logic [31:0] w_fetch_word;
  logic        w_advance;
  logic [31:0] w_seq_target;

  // A redirect seen while stalled comes from an unresolved branch, so it is
  // ignored.
  assign w_live_redir = redir_valid & ~stall;

`ifdef FETCH_ADEL_CHECK_EN
  assign w_bad_pc = (r_pc[1:0] != 2'b00) || (r_pc < PC_LO) || (r_pc > PC_HI);
`else
  assign w_bad_pc = 1'b0;
`endif

  // A bad PC never reaches memory. It is completed at once as an internal
  // grant that carries a zero instruction word.
  assign w_gnt        = imem_gnt | w_bad_pc;
  assign w_fetch_word = w_bad_pc ? 32'h0 : imem_rdata;

  // Priority for the next PC: live redirect, then buffered redirect, then
  // the sequential address.
  assign w_seq_target = w_live_redir ? redir_target :
                        r_pend       ? r_pend_tgt   :
                                       r_pc + 32'd4;

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_pend_next     = r_pend;
    w_pend_tgt_next = r_pend_tgt;
    w_ibuf_next     = r_ibuf;
    w_ibuf_exc_next = r_ibuf_exc;
    w_instr_d_next  = r_instr_d;
    w_pc_d_next     = r_pc_d;
    w_valid_d_next  = r_valid_d;
    w_exc_d_next    = r_exc_d;
    w_advance       = 1'b0;
    imem_req        = 1'b0;

    case (r_state)
      ST_FETCH: begin
        imem_req = ~w_bad_pc;
        if (w_gnt && !stall) begin
          w_instr_d_next = w_fetch_word;
          w_pc_d_next    = r_pc;
          w_valid_d_next = 1'b1;
          w_exc_d_next   = w_bad_pc;
          w_advance      = 1'b1;
        end else if (w_gnt && stall) begin
          // The word is granted but D is frozen. Park the word so that it
          // is delivered exactly once when the stall releases.
          w_ibuf_next     = w_fetch_word;
          w_ibuf_exc_next = w_bad_pc;
          w_state_next    = ST_HOLD;
        end else if (!stall) begin
          // Waiting on memory: pass a bubble to D and keep pc_D unchanged.
          w_instr_d_next = 32'h0;
          w_valid_d_next = 1'b0;
          w_exc_d_next   = 1'b0;
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          w_instr_d_next = r_ibuf;
          w_pc_d_next    = r_pc;
          w_valid_d_next = 1'b1;
          w_exc_d_next   = r_ibuf_exc;
          w_advance      = 1'b1;
          w_state_next   = ST_FETCH;
        end
      end
      default: w_state_next = ST_FETCH;
    endcase

    if (w_advance) begin
      // The instruction that just entered D is the delay slot of any
      // redirect consumed here.
      w_pc_next   = w_seq_target;
      w_pend_next = 1'b0;
    end else if (w_live_redir) begin
      w_pend_next     = 1'b1;
      w_pend_tgt_next = redir_target;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_FETCH;
      r_pc       <= RESET_PC;
      r_pend     <= 1'b0;
      r_pend_tgt <= 32'h0;
      r_ibuf     <= 32'h0;
      r_ibuf_exc <= 1'b0;
      r_instr_d  <= 32'h0;
      r_pc_d     <= 32'h0;
      r_valid_d  <= 1'b0;
      r_exc_d    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_pend     <= w_pend_next;
      r_pend_tgt <= w_pend_tgt_next;
      r_ibuf     <= w_ibuf_next;
      r_ibuf_exc <= w_ibuf_exc_next;
      r_instr_d  <= w_instr_d_next;
      r_pc_d     <= w_pc_d_next;
      r_valid_d  <= w_valid_d_next;
      r_exc_d    <= w_exc_d_next;
    end
  end

  assign imem_addr  = r_pc;
  assign pc_F       = r_pc;
  assign instr_D    = r_instr_d;
  assign pc_D       = r_pc_d;
  assign pc8_D      = r_pc_d + 32'd8;
  assign valid_D    = r_valid_d;
`ifdef FETCH_ADEL_CHECK_EN
  assign exc_adel_D = r_exc_d;
`else
  assign exc_adel_D = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl. The memory model returns addr ^ 0xCAFE0000.
module tb_fetch_pc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic [31:0] imem_rdata;
  logic [31:0] pc_F;
  logic [31:0] instr_D;
  logic [31:0] pc_D;
  logic [31:0] pc8_D;
  logic        valid_D;
  logic        exc_adel_D;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] KEY = 32'hCAFE_0000;

  fetch_pc_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rdata   (imem_rdata),
    .pc_F         (pc_F),
    .instr_D      (instr_D),
    .pc_D         (pc_D),
    .pc8_D        (pc8_D),
    .valid_D      (valid_D),
    .exc_adel_D   (exc_adel_D)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ KEY;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the F/D register and the PC after one step.
  task automatic chk_fd(input string tag, input logic [31:0] e_pcf, input logic [31:0] e_pcd,
                        input logic e_valid, input logic [31:0] e_instr, input logic e_req);
    chk({tag, ".pc_F"}, pc_F, e_pcf);
    chk({tag, ".imem_addr"}, imem_addr, e_pcf);
    chk({tag, ".pc_D"}, pc_D, e_pcd);
    chk({tag, ".pc8_D"}, pc8_D, e_pcd + 32'd8);
    chk({tag, ".valid_D"}, {31'd0, valid_D}, {31'd0, e_valid});
    chk({tag, ".instr_D"}, instr_D, e_instr);
    chk({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, e_req});
    $display("step %-10s pc_F=%08h pc_D=%08h valid_D=%0b instr_D=%08h req=%0b",
             tag, pc_F, pc_D, valid_D, instr_D, imem_req);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redir_valid = 1'b0; redir_target = 32'h0; imem_gnt = 1'b0;
    tick();
    tick();
    chk_fd("reset", 32'h3000, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("reset.exc", {31'd0, exc_adel_D}, 32'd0);

    // Back-to-back grants
    reset = 1'b0; imem_gnt = 1'b1;
    tick(); chk_fd("seq0", 32'h3004, 32'h3000, 1'b1, 32'h3000 ^ KEY, 1'b1);
    tick(); chk_fd("seq1", 32'h3008, 32'h3004, 1'b1, 32'h3004 ^ KEY, 1'b1);

    // Live redirect consumed while fetching 0x3008; 0x3008 is the delay slot
    redir_valid = 1'b1; redir_target = 32'h3100;
    tick(); chk_fd("redir", 32'h3100, 32'h3008, 1'b1, 32'h3008 ^ KEY, 1'b1);
    redir_target = 32'h300C;
    tick(); chk_fd("redir2", 32'h300C, 32'h3100, 1'b1, 32'h3100 ^ KEY, 1'b1);

    // Redirect to 0x3200 while 0x300C waits for its grant -> buffered
    imem_gnt = 1'b0; redir_target = 32'h3200;
    tick(); chk_fd("wait0", 32'h300C, 32'h3100, 1'b0, 32'h0, 1'b1);
    // A redirect seen under stall is ignored
    redir_target = 32'h3300; stall = 1'b1;
    tick(); chk_fd("wait1", 32'h300C, 32'h3100, 1'b0, 32'h0, 1'b1);
    redir_valid = 1'b0; stall = 1'b0; imem_gnt = 1'b1;
    tick(); chk_fd("pend", 32'h3200, 32'h300C, 1'b1, 32'h300C ^ KEY, 1'b1);
    tick(); chk_fd("seq2", 32'h3204, 32'h3200, 1'b1, 32'h3200 ^ KEY, 1'b1);

    // Grant under stall -> HOLD for three cycles, with no request issued
    stall = 1'b1;
    tick(); chk_fd("hold0", 32'h3204, 32'h3200, 1'b1, 32'h3200 ^ KEY, 1'b0);
    redir_valid = 1'b1; redir_target = 32'h3400;
    tick(); chk_fd("hold1", 32'h3204, 32'h3200, 1'b1, 32'h3200 ^ KEY, 1'b0);
    redir_valid = 1'b0;
    tick(); chk_fd("hold2", 32'h3204, 32'h3200, 1'b1, 32'h3200 ^ KEY, 1'b0);
    stall = 1'b0; imem_gnt = 1'b0;
    tick(); chk_fd("release", 32'h3208, 32'h3204, 1'b1, 32'h3204 ^ KEY, 1'b1);
    tick(); chk_fd("once", 32'h3208, 32'h3204, 1'b0, 32'h0, 1'b1);

    // Buffer a redirect, then reset asynchronously: the redirect is discarded
    redir_valid = 1'b1; redir_target = 32'h3400;
    tick(); chk_fd("pend2", 32'h3208, 32'h3204, 1'b0, 32'h0, 1'b1);
    redir_valid = 1'b0;
    #2 reset = 1'b1;
    #1 chk_fd("areset", 32'h3000, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    reset = 1'b0; imem_gnt = 1'b1;
    tick(); chk_fd("post_rst", 32'h3004, 32'h3000, 1'b1, 32'h3000 ^ KEY, 1'b1);

`ifndef FETCH_ADEL_CHECK_EN
    // 32-bit wrap of the sequential PC and of the link address
    redir_valid = 1'b1; redir_target = 32'hFFFF_FFFC;
    tick(); chk_fd("to_top", 32'hFFFF_FFFC, 32'h3004, 1'b1, 32'h3004 ^ KEY, 1'b1);
    redir_valid = 1'b0;
    tick(); chk_fd("wrap", 32'h0, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC ^ KEY, 1'b1);
    chk("wrap.exc", {31'd0, exc_adel_D}, 32'd0);
`else
    // Bad fetch addresses: no request, zero instruction, exception flag set
    redir_valid = 1'b1; redir_target = 32'h3002;
    tick(); chk_fd("to_bad", 32'h3002, 32'h3004, 1'b1, 32'h3004 ^ KEY, 1'b0);
    chk("to_bad.exc", {31'd0, exc_adel_D}, 32'd0);
    redir_target = 32'h7000; imem_gnt = 1'b0;
    tick(); chk_fd("adel0", 32'h7000, 32'h3002, 1'b1, 32'h0, 1'b0);
    chk("adel0.exc", {31'd0, exc_adel_D}, 32'd1);
    redir_valid = 1'b0;
    tick(); chk_fd("adel1", 32'h7004, 32'h7000, 1'b1, 32'h0, 1'b0);
    chk("adel1.exc", {31'd0, exc_adel_D}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Fetch-stage sequencer owning the program counter and the F/D handoff register of the P6 pipeline. Each cycle it chooses the next PC: sequential, a live redirect from the D-stage branch/jump logic, or a buffered redirect. It issues instruction-memory requests that may take several cycles, and absorbs hazard-unit stalls without losing a granted instruction. MIPS delay-slot semantics are preserved: the instruction fetched after a branch is always delivered.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_3000: PC value after reset.
- `PC_LO`, default 32'h0000_3000: lowest legal fetch address, used only with the configuration macro.
- `PC_HI`, default 32'h0000_6FFC: highest legal fetch address, used only with the configuration macro.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `stall` in 1: hazard-unit freeze of F and D.
- `redir_valid` in 1: D-stage branch taken, jal or jr this cycle.
- `redir_target` in 32: redirect destination.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, always equal to `pc_F`.
- `imem_gnt` in 1: request accepted; `imem_rdata` is valid in the same cycle.
- `imem_rdata` in 32: instruction word.
- `pc_F` out 32: current PC.
- `instr_D` out 32: F/D instruction.
- `pc_D` out 32: F/D PC.
- `pc8_D` out 32: `pc_D`+8, the link address.
- `valid_D` out 1: the F/D register holds a real instruction.
- `exc_adel_D` out 1: fetch address error (configuration-dependent).

## Operation
- States: FETCH, HOLD. Internal registers: `pc`, `pend` plus `pend_tgt` (buffered redirect), `ibuf` (captured instruction).
- `redir_valid` is sampled only when `stall`=0. It is ignored while stalled because a stalled branch is unresolved.
- Next-PC rule, applied whenever the PC advances:
  - If a live sampled redirect is present, next PC = `redir_target`.
  - Otherwise, if `pend` is set, next PC = `pend_tgt`.
  - Otherwise, next PC = `pc`+4, using 32-bit wrap-around.
  - `pend` clears on every advance.
- A live redirect that is not consumed by an advance sets `pend` and loads `pend_tgt`. A later live redirect overwrites `pend_tgt`.
- FETCH state:
  - `imem_req`=1.
  - `gnt`=1 and `stall`=0: F/D loads {`imem_rdata`, `pc`, valid=1}. The PC advances.
  - `gnt`=1 and `stall`=1: `ibuf` is loaded with `imem_rdata`, and the state goes to HOLD. The PC and F/D are unchanged.
  - `gnt`=0 and `stall`=0: F/D loads a bubble (valid=0, instr=0, pc unchanged). The PC holds.
  - `gnt`=0 and `stall`=1: everything holds.
- HOLD state:
  - `imem_req`=0.
  - `stall`=0: F/D loads {`ibuf`, `pc`, 1}, the PC advances, and the state returns to FETCH.
  - `stall`=1: everything holds.
- A redirect consumed by an advance means the loaded instruction is the delay slot, and fetch continues at the target.

## Timing
- Reset (asynchronous):
  - `pc_F`=`RESET_PC`; state=FETCH; `pend`=0; `ibuf`=0.
  - `instr_D`=0, `pc_D`=0, `valid_D`=0, `exc_adel_D`=0.
  - `imem_req`=1 from the first cycle after reset deasserts. `pc8_D`=8 during reset.
- Request-to-D latency is 1 edge after `gnt` when not stalled. With `gnt` asserted every cycle, throughput is 1 instruction per cycle.
- `imem_addr` is stable while `imem_req`=1 and `gnt`=0. The memory may grant in any later cycle.
- No request is issued in HOLD. Each fetched word is therefore delivered exactly once.
- `pc8_D` is combinational from `pc_D`. All other outputs are registered.
- If `reset` asserts mid-wait or in HOLD, any pending redirect and the buffered instruction are discarded.

## Configuration
- Macro `FETCH_ADEL_CHECK_EN`.
- Defined:
  - A PC is bad if `pc[1:0]`≠0, or `pc` < `PC_LO`, or `pc` > `PC_HI`.
  - With a bad PC in FETCH, `imem_req`=0 and the access is treated as an internal grant.
  - F/D loads {instr=0, `pc`, valid=1, `exc_adel_D`=1}, subject to the same stall and HOLD rules. The PC advances normally.
  - Good fetches load `exc_adel_D`=0.
- Not defined: no check is made, and `exc_adel_D` is constant 0.

## Test plan
- Reset, then `gnt` tied 1: `pc_F` steps 0x3000, 0x3004, 0x3008; `valid_D`=1 from the second edge; `pc8_D`=0x3008 while `pc_D`=0x3000.
- `gnt` asserted on the third cycle of each request: `valid_D` shows 2 bubbles between instructions, and `imem_addr` stays constant during each wait.
- `gnt`=1 with `stall`=1 for 3 cycles at PC 0x3010: state is HOLD, `imem_req`=0, and F/D is held. After release, the word from 0x3010 appears once, and the next request is 0x3014.
- `redir_valid`=1 with target 0x3100 while fetching 0x3008 with `gnt`=1: F/D gets 0x3008 (delay slot), and the next `pc_F`=0x3100.
- Redirect to 0x3200 while the 0x300C fetch waits 2 cycles for `gnt`: `pend` is set; the 0x300C word is delivered, then `pc_F`=0x3200. A redirect presented with `stall`=1 has no effect.
- With `FETCH_ADEL_CHECK_EN` defined, redirect to 0x3002 and then to 0x7000: `imem_req`=0 for each, `exc_adel_D`=1 with `instr_D`=0, and `pc_D` equals the bad address.
